// File: rtl/vmem_wq_pkg.sv
// Shared types and helpers for the VMEM posted-write queue: lane/offset map,
// queue entry layout and byte-enable population count.
package vmem_wq_pkg;

  localparam int LANES       = 4;
  localparam int LINE_ADDR_W = 13;
  localparam int ENTRY_ADDR_W = LINE_ADDR_W + 2;

  // Byte-enable bit N selects the byte at offset (3 - N) within the word.
  localparam logic [1:0] OFFSET_LANE3 = 2'd0;
  localparam logic [1:0] OFFSET_LANE2 = 2'd1;
  localparam logic [1:0] OFFSET_LANE1 = 2'd2;
  localparam logic [1:0] OFFSET_LANE0 = 2'd3;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } vmem_entry_t;

  function automatic logic [2:0] popcount4(input logic [3:0] bits);
    return {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};
  endfunction

  function automatic logic [1:0] lane_for_offset(input logic [1:0] offset);
    return 2'd3 - offset;
  endfunction

endpackage

// File: rtl/vmem_lane_unpack.sv
// Splits one CPU byte-lane store into up to four single-byte queue entries,
// packed towards slot 0 in ascending byte-offset order.
module vmem_lane_unpack
  import vmem_wq_pkg::*;
(
  input  logic [29:0]                   cpu_addr,
  input  logic [3:0]                    cpu_byte_en,
  input  logic [31:0]                   cpu_data,
  output vmem_entry_t [LANES-1:0]       entries,
  output logic [2:0]                    need
);

  logic [2:0] slot;
  logic [1:0] offset;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^cpu_addr[29:LINE_ADDR_W];

  // Enabled lanes are compacted so slot k always holds the k-th byte to write.
  always_comb begin
    entries = '0;
    slot    = '0;
    offset  = '0;
    for (int off = 0; off < LANES; off++) begin
      offset = 2'(off);
      if (cpu_byte_en[lane_for_offset(offset)]) begin
        entries[slot[1:0]].addr = {cpu_addr[LINE_ADDR_W-1:0], offset};
        entries[slot[1:0]].data = cpu_data[8*off +: 8];
        slot = slot + 3'd1;
      end
    end
  end

  assign need = popcount4(cpu_byte_en);

endmodule

// File: rtl/vmem_write_queue.sv
// Posted-write buffer and drain scheduler for text-mode video memory.
// Optional statistics outputs are enabled with `define VMEM_WQ_STATS_EN.
module vmem_write_queue
  import vmem_wq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int VADDR_W = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_wr,
  input  logic [29:0]                cpu_addr,
  input  logic [3:0]                 cpu_byte_en,
  input  logic [31:0]                cpu_data,
  output logic                       stall,
  output logic                       vga_wen,
  output logic [VADDR_W-1:0]         vga_addr,
  output logic [7:0]                 vga_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       idle
`ifdef VMEM_WQ_STATS_EN
  ,
  output logic [31:0]                stat_stall_cycles,
  output logic [$clog2(DEPTH):0]     stat_max_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  vmem_entry_t [LANES-1:0] new_entries;
  logic [2:0]              need;
  vmem_entry_t             mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LW-1:0]           room;
  logic [LW-1:0]           level_next;
  logic                    push;
  logic                    pop;

  vmem_lane_unpack u_unpack (
    .cpu_addr    (cpu_addr),
    .cpu_byte_en (cpu_byte_en),
    .cpu_data    (cpu_data),
    .entries     (new_entries),
    .need        (need)
  );

  // Room is judged on the pre-pop level, so a same-edge pop never helps a push.
  assign room       = LW'(DEPTH) - level;
  assign stall      = cpu_wr && (room < LW'(need));
  assign push       = cpu_wr && !stall && (need != 3'd0);
  assign pop        = (level != '0);
  assign level_next = level + (push ? LW'(need) : '0) - (pop ? LW'(1) : '0);
  assign idle       = (level == '0) && !vga_wen;

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++) begin
        if (3'(i) < need) begin
          mem[wr_ptr + PW'(i)] <= new_entries[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      vga_wen  <= 1'b0;
      vga_addr <= '0;
      vga_data <= '0;
    end else begin
      level <= level_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(need);
      end
      // Address and data only move when a write is issued, holding otherwise.
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        vga_wen  <= 1'b1;
        vga_addr <= VADDR_W'(mem[rd_ptr].addr);
        vga_data <= mem[rd_ptr].data;
      end else begin
        vga_wen  <= 1'b0;
      end
    end
  end

`ifdef VMEM_WQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cycles <= '0;
      stat_max_level    <= '0;
    end else begin
      if (stall) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
      if (level_next > stat_max_level) begin
        stat_max_level <= level_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vmem_write_queue.sv
// Self-checking bench for vmem_write_queue: queue-based reference model checked
// every cycle, plus directed stores with literal expected write sequences.
module tb_vmem_write_queue;

  localparam int DEPTH   = 8;
  localparam int VADDR_W = 15;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cpu_wr;
  logic [29:0]        cpu_addr;
  logic [3:0]         cpu_byte_en;
  logic [31:0]        cpu_data;
  logic               stall;
  logic               vga_wen;
  logic [VADDR_W-1:0] vga_addr;
  logic [7:0]         vga_data;
  logic [LW-1:0]      level;
  logic               idle;
`ifdef VMEM_WQ_STATS_EN
  logic [31:0]        stat_stall_cycles;
  logic [LW-1:0]      stat_max_level;
  int unsigned        exp_stall_cycles = 0;
  int unsigned        exp_max_level = 0;
`endif

  vmem_write_queue #(.DEPTH(DEPTH), .VADDR_W(VADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_byte_en (cpu_byte_en),
    .cpu_data    (cpu_data),
    .stall       (stall),
    .vga_wen     (vga_wen),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .level       (level),
    .idle        (idle)
`ifdef VMEM_WQ_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_max_level    (stat_max_level)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: pending bytes as {byte address, data}, plus the write port.
  logic [22:0]  mq[$];
  logic [22:0]  seen[$];
  logic         exp_wen  = 1'b0;
  logic [14:0]  exp_addr = '0;
  logic [7:0]   exp_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int needOf(input logic [3:0] b);
    return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
  endfunction

  // Model: a posted write leaves the queue head on every edge it is non-empty;
  // a store is taken whole when the pre-edge free space covers all its bytes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_wen  = 1'b0;
      exp_addr = '0;
      exp_data = '0;
`ifdef VMEM_WQ_STATS_EN
      exp_stall_cycles = 0;
      exp_max_level    = 0;
`endif
    end else begin
      int n;
      bit acc;
      n   = needOf(cpu_byte_en);
      acc = (cpu_wr === 1'b1) && ((DEPTH - mq.size()) >= n);
`ifdef VMEM_WQ_STATS_EN
      if (cpu_wr === 1'b1 && !acc) exp_stall_cycles++;
`endif
      if (mq.size() > 0) begin
        {exp_addr, exp_data} = mq.pop_front();
        exp_wen = 1'b1;
      end else begin
        exp_wen = 1'b0;
      end
      if (acc) begin
        for (int off = 0; off < 4; off++) begin
          if (cpu_byte_en[3-off]) mq.push_back({cpu_addr[12:0], 2'(off), cpu_data[8*off +: 8]});
        end
      end
`ifdef VMEM_WQ_STATS_EN
      if (mq.size() > exp_max_level) exp_max_level = mq.size();
`endif
    end
  end

  always @(negedge clk) begin
    checkOutput("stall", 32'(stall), 32'((cpu_wr === 1'b1) && ((DEPTH - mq.size()) < needOf(cpu_byte_en))));
    checkOutput("vga_wen", 32'(vga_wen), 32'(exp_wen));
    checkOutput("vga_addr", 32'(vga_addr), 32'(exp_addr));
    checkOutput("vga_data", 32'(vga_data), 32'(exp_data));
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("idle", 32'(idle), 32'((mq.size() == 0) && !exp_wen));
`ifdef VMEM_WQ_STATS_EN
    checkOutput("stat_stall_cycles", stat_stall_cycles, exp_stall_cycles);
    checkOutput("stat_max_level", 32'(stat_max_level), exp_max_level);
`endif
    if (vga_wen === 1'b1) seen.push_back({vga_addr, vga_data});
  end

  // Called and returns at posedge+1; holds the store until it is accepted.
  task automatic applyStimulus(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d,
                               output int stalls);
    bit s;
    bit done;
    stalls = 0;
    done   = 1'b0;
    cpu_wr = 1'b1; cpu_addr = a; cpu_byte_en = b; cpu_data = d;
    for (int k = 0; k < 64 && !done; k++) begin
      #8;
      s = stall;
      @(posedge clk);
      #1;
      if (!s) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL store_accept_timeout: got stalled, expected accept");
    end
    cpu_wr = 1'b0; cpu_byte_en = 4'b0000;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 100; k++) begin
      if (idle === 1'b1) return;
      @(posedge clk);
      #1;
    end
    tests++; fails++;
    $display("[TB] FAIL idle_timeout: got busy, expected idle");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int total;
    logic [22:0] exp_b [4];
    exp_b = '{{15'h00C, 8'h41}, {15'h00D, 8'h42}, {15'h00E, 8'h43}, {15'h00F, 8'h44}};
    cpu_wr = 1'b0; cpu_addr = '0; cpu_byte_en = '0; cpu_data = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_wen", 32'(vga_wen), 32'd0);
    checkOutput("rst_addr", 32'(vga_addr), 32'd0);
    checkOutput("rst_data", 32'(vga_data), 32'd0);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte store");
    seen.delete();
    applyStimulus(30'h10, 4'b1000, 32'h41, n);
    checkOutput("a_stalls", n, 0);
    checkOutput("a_wen_same_edge", 32'(vga_wen), 32'd0);
    @(posedge clk); #1;
    checkOutput("a_wen", 32'(vga_wen), 32'd1);
    checkOutput("a_addr", 32'(vga_addr), 32'h040);
    checkOutput("a_data", 32'(vga_data), 32'h41);
    @(posedge clk); #1;
    checkOutput("a_wen_off", 32'(vga_wen), 32'd0);
    checkOutput("a_idle", 32'(idle), 32'd1);
    checkOutput("a_addr_hold", 32'(vga_addr), 32'h040);

    $display("[TB] four byte store");
    seen.delete();
    applyStimulus(30'h3, 4'b1111, 32'h44434241, n);
    waitIdle();
    checkOutput("b_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("b_byte", 32'(seen[i]), 32'(exp_b[i]));

    $display("[TB] stall when full");
    seen.delete();
    applyStimulus(30'h100, 4'b1111, 32'h03020100, n);
    checkOutput("c_stalls1", n, 0);
    applyStimulus(30'h101, 4'b1111, 32'h07060504, n);
    checkOutput("c_stalls2", n, 0);
    checkOutput("c_level2", 32'(level), 32'd7);
    applyStimulus(30'h102, 4'b1111, 32'h0b0a0908, n);
    checkOutput("c_stalls3", n, 3);
    applyStimulus(30'h103, 4'b1000, 32'h0000000c, n);
    checkOutput("c_stalls4", n, 0);
    checkOutput("c_level4", 32'(level), 32'd7);
    waitIdle();
    checkOutput("c_count", seen.size(), 13);
    for (int i = 0; i < 13; i++) checkOutput("c_byte", 32'(seen[i]), 32'({15'(16'h400 + i), 8'(i)}));

    $display("[TB] streaming one byte per cycle");
    seen.delete();
    total = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(30'(32'h80 + i), 4'b1000, 32'(32'h50 + i), n);
      total += n;
      checkOutput("d_level", 32'(level), 32'd1);
      if (i < 9) begin
        cpu_wr = 1'b1; cpu_byte_en = 4'b1000;
      end
    end
    checkOutput("d_stalls", total, 0);
    waitIdle();
    checkOutput("d_count", seen.size(), 10);
    for (int i = 0; i < 10; i++) checkOutput("d_byte", 32'(seen[i]), 32'({15'(16'h200 + 4*i), 8'(8'h50 + i)}));

    $display("[TB] reset mid-operation");
    applyStimulus(30'h300, 4'b1111, 32'hA3A2A1A0, n);
    applyStimulus(30'h301, 4'b0011, 32'hB3B2B1B0, n);
    checkOutput("e_level_pre", 32'(level), 32'd5);
    rst = 1'b0;
    #1;
    checkOutput("e_wen", 32'(vga_wen), 32'd0);
    checkOutput("e_level", 32'(level), 32'd0);
    checkOutput("e_addr", 32'(vga_addr), 32'd0);
    checkOutput("e_idle", 32'(idle), 32'd1);
    seen.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("e_no_stale", seen.size(), 0);
    checkOutput("e_level_post", 32'(level), 32'd0);

    $display("[TB] empty byte enable");
    seen.delete();
    applyStimulus(30'h5, 4'b0000, 32'hFFFFFFFF, n);
    checkOutput("f_stalls", n, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("f_no_write", seen.size(), 0);
    checkOutput("f_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
